// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: funct3 codes, compare flags,
// predictor counter constants and the condition/legality helpers.
package branch_pkg;

  localparam int unsigned F3_W = 3;
  localparam int unsigned CTR_W = 2;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  // Predictor counters start weakly not-taken and saturate at both ends
  localparam logic [CTR_W-1:0] CTR_INIT = 2'b01;
  localparam logic [CTR_W-1:0] CTR_MIN  = 2'b00;
  localparam logic [CTR_W-1:0] CTR_MAX  = 2'b11;

  typedef struct packed {
    logic eq;
    logic lt;
    logic ltu;
  } cmp_flags_t;

  // Only 010 and 011 are unused encodings in the branch funct3 space
  function automatic logic f3_illegal(input logic [F3_W-1:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  // Pick the branch condition from precomputed compare flags; illegal codes never take
  function automatic logic cond_taken(input logic [F3_W-1:0] f3, input cmp_flags_t f);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:  t = f.eq;
      F3_BNE:  t = !f.eq;
      F3_BLT:  t = f.lt;
      F3_BGE:  t = !f.lt;
      F3_BLTU: t = f.ltu;
      F3_BGEU: t = !f.ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: ENTRIES 2-bit saturating counters indexed by pc word bits.
// Lookup is combinational and sees the pre-update value on a same-index collision.
module branch_bht
  import branch_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] i_lookup_pc,
  output logic            o_lookup_taken,
  input  logic            i_upd_en,
  input  logic [PC_W-1:0] i_upd_pc,
  input  logic            i_upd_taken
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [CTR_W-1:0] r_ctr [ENTRIES];
  logic [IDX_W-1:0] w_lookup_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic [CTR_W-1:0] w_upd_cur;
  logic [CTR_W-1:0] w_upd_next;
  logic             w_unused_pc_bits;

  assign w_lookup_idx     = i_lookup_pc[IDX_W+1:2];
  assign w_upd_idx        = i_upd_pc[IDX_W+1:2];
  assign w_upd_cur        = r_ctr[w_upd_idx];
  assign o_lookup_taken   = r_ctr[w_lookup_idx][CTR_W-1];
  assign w_unused_pc_bits = ^{i_lookup_pc[PC_W-1:IDX_W+2], i_lookup_pc[1:0],
                              i_upd_pc[PC_W-1:IDX_W+2], i_upd_pc[1:0]};

  // Saturating step toward the resolved direction
  always_comb begin
    w_upd_next = w_upd_cur;
    if (i_upd_taken) begin
      if (w_upd_cur != CTR_MAX) w_upd_next = w_upd_cur + CTR_W'(1);
    end else begin
      if (w_upd_cur != CTR_MIN) w_upd_next = w_upd_cur - CTR_W'(1);
    end
  end

  // Counter storage; reset returns every entry to weak not-taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_INIT;
    end else if (i_upd_en) begin
      r_ctr[w_upd_idx] <= w_upd_next;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Conditional branch resolver: compares raw operands, selects the funct3 condition,
// computes target and mispredict, with a PIPE-deep valid/ready pipeline and flush.
// Optional predictor table enabled by defining BRANCH_BHT_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned PIPE        = 1,
  parameter int unsigned BHT_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [F3_W-1:0] in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [PC_W-1:0] in_pc,
  input  logic [PC_W-1:0] in_imm,
  input  logic            in_pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [PC_W-1:0] out_target,
  output logic            out_mispredict,
  output logic            out_illegal
`ifdef BRANCH_BHT_EN
  ,
  input  logic [PC_W-1:0] bht_pc,
  output logic            bht_taken
`endif
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  cmp_flags_t      w_in_flags;
  cmp_flags_t      w_src_flags;
  logic            w_src_valid;
  logic [PC_W-1:0] w_src_pc;
  logic [PC_W-1:0] w_src_imm;
  logic [F3_W-1:0] w_src_f3;
  logic            w_src_pred;
  logic            w_fin_adv;
  logic            w_fin_load;
  logic            w_taken;
  logic            w_illegal;
  logic [PC_W-1:0] w_target;

  logic            r_out_valid;
  logic            r_out_taken;
  logic [PC_W-1:0] r_out_target;
  logic            r_out_mispredict;
  logic            r_out_illegal;

  // Full-width operand compares
  assign w_in_flags.eq  = (in_rs1 == in_rs2);
  assign w_in_flags.lt  = ($signed(in_rs1) < $signed(in_rs2));
  assign w_in_flags.ltu = (in_rs1 < in_rs2);

  // Output stage can take a new entry when empty or being drained this cycle
  assign w_fin_adv = !r_out_valid || out_ready;

  generate
    if (PIPE == 2) begin : g_pipe2
      logic            r_s1_valid;
      cmp_flags_t      r_s1_flags;
      logic [PC_W-1:0] r_s1_pc;
      logic [PC_W-1:0] r_s1_imm;
      logic [F3_W-1:0] r_s1_f3;
      logic            r_s1_pred;
      logic            w_s1_load;

      assign in_ready  = flush || !r_s1_valid || w_fin_adv;
      assign w_s1_load = in_valid && in_ready && !flush;

      // Compare stage: latch flags and the payload needed for select/add
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1_valid <= 1'b0;
          r_s1_flags <= '0;
          r_s1_pc    <= '0;
          r_s1_imm   <= '0;
          r_s1_f3    <= '0;
          r_s1_pred  <= 1'b0;
        end else begin
          if (flush)          r_s1_valid <= 1'b0;
          else if (w_s1_load) r_s1_valid <= 1'b1;
          else if (w_fin_adv) r_s1_valid <= 1'b0;
          if (w_s1_load) begin
            r_s1_flags <= w_in_flags;
            r_s1_pc    <= in_pc;
            r_s1_imm   <= in_imm;
            r_s1_f3    <= in_funct3;
            r_s1_pred  <= in_pred_taken;
          end
        end
      end

      assign w_src_valid = r_s1_valid;
      assign w_src_flags = r_s1_flags;
      assign w_src_pc    = r_s1_pc;
      assign w_src_imm   = r_s1_imm;
      assign w_src_f3    = r_s1_f3;
      assign w_src_pred  = r_s1_pred;
    end else begin : g_pipe1
      assign in_ready    = flush || w_fin_adv;
      assign w_src_valid = in_valid;
      assign w_src_flags = w_in_flags;
      assign w_src_pc    = in_pc;
      assign w_src_imm   = in_imm;
      assign w_src_f3    = in_funct3;
      assign w_src_pred  = in_pred_taken;
    end
  endgenerate

  // Condition select and target add feeding the output stage
  assign w_illegal  = f3_illegal(w_src_f3);
  assign w_taken    = !w_illegal && cond_taken(w_src_f3, w_src_flags);
  assign w_target   = w_taken ? (w_src_pc + w_src_imm) : (w_src_pc + PC_STEP);
  assign w_fin_load = w_src_valid && w_fin_adv && !flush;

  // Output stage: results held until the consumer takes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid      <= 1'b0;
      r_out_taken      <= 1'b0;
      r_out_target     <= '0;
      r_out_mispredict <= 1'b0;
      r_out_illegal    <= 1'b0;
    end else begin
      if (flush)          r_out_valid <= 1'b0;
      else if (w_fin_adv) r_out_valid <= w_src_valid;
      if (w_fin_load) begin
        r_out_taken      <= w_taken;
        r_out_target     <= w_target;
        r_out_mispredict <= w_taken ^ w_src_pred;
        r_out_illegal    <= w_illegal;
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_taken      = r_out_taken;
  assign out_target     = r_out_target;
  assign out_mispredict = r_out_mispredict;
  assign out_illegal    = r_out_illegal;

`ifdef BRANCH_BHT_EN
  logic [PC_W-1:0] r_out_pc;

  // Branch pc travels with the result so the predictor trains on the right entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_out_pc <= '0;
    else if (w_fin_load) r_out_pc <= w_src_pc;
  end

  branch_bht #(
    .PC_W    (PC_W),
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_lookup_pc    (bht_pc),
    .o_lookup_taken (bht_taken),
    .i_upd_en       (r_out_valid && out_ready && !r_out_illegal),
    .i_upd_pc       (r_out_pc),
    .i_upd_taken    (r_out_taken)
  );
`else
  logic [31:0] w_unused_bht_cfg;
  assign w_unused_bht_cfg = 32'(BHT_ENTRIES);
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: a PIPE=1 and a PIPE=2 instance share stimulus;
// directed table, handshake/flush/reset sequences, then random traffic vs a model.
module tb_branch_resolve_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PC_W = 32;
  localparam int unsigned NB   = 16;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic        mis;
    logic        ill;
  } res_t;

  typedef struct packed {
    res_t        r;
    logic [31:0] pc;
  } sb_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, pc, imm;
    logic        pred;
    logic        tk;
    logic [31:0] tg;
    logic        mi, il;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, out_ready, pred;
  logic [2:0]  f3;
  logic [31:0] rs1, rs2, pc, imm;
  logic        ir [2];
  logic        ov [2];
  logic        ot [2];
  logic        om [2];
  logic        oi [2];
  logic [31:0] otg [2];
`ifdef BRANCH_BHT_EN
  logic [31:0] bht_pc;
  logic        bt [2];
`endif

  int errors = 0;
  int checks = 0;

  sb_t  q0[$];
  sb_t  q1[$];
  logic hold [2];
  res_t prev [2];
  int   bm [2][NB];

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .PC_W(PC_W), .PIPE(1), .BHT_ENTRIES(NB)) u_p1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_funct3(f3), .in_rs1(rs1), .in_rs2(rs2), .in_pc(pc), .in_imm(imm),
    .in_pred_taken(pred), .out_valid(ov[0]), .out_ready(out_ready), .out_taken(ot[0]),
    .out_target(otg[0]), .out_mispredict(om[0]), .out_illegal(oi[0])
`ifdef BRANCH_BHT_EN
    , .bht_pc(bht_pc), .bht_taken(bt[0])
`endif
  );

  branch_resolve_unit #(.XLEN(XLEN), .PC_W(PC_W), .PIPE(2), .BHT_ENTRIES(NB)) u_p2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_funct3(f3), .in_rs1(rs1), .in_rs2(rs2), .in_pc(pc), .in_imm(imm),
    .in_pred_taken(pred), .out_valid(ov[1]), .out_ready(out_ready), .out_taken(ot[1]),
    .out_target(otg[1]), .out_mispredict(om[1]), .out_illegal(oi[1])
`ifdef BRANCH_BHT_EN
    , .bht_pc(bht_pc), .bht_taken(bt[1])
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: branch semantics straight from the ISA definition
  function automatic res_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] p, input logic [31:0] im, input logic pr);
    res_t r;
    logic t, legal;
    t = 1'b0;
    legal = 1'b1;
    case (c)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd4: t = ($signed(a) < $signed(b));
      3'd5: t = ($signed(a) >= $signed(b));
      3'd6: t = (a < b);
      3'd7: t = (a >= b);
      default: legal = 1'b0;
    endcase
    r.taken  = t;
    r.target = t ? (p + im) : (p + 32'd4);
    r.mis    = (t != pr);
    r.ill    = !legal;
    return r;
  endfunction

  function automatic int bidx(input logic [31:0] p);
    return int'((p / 32'd4) % 32'(NB));
  endfunction

  task automatic bht_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < int'(NB); i++) bm[k][i] = 1;
  endtask

  // Per-instance scoreboard, hold-stability and predictor checks
  task automatic mon(input int k);
    res_t act;
    sb_t  e;
    act.taken  = ot[k];
    act.target = otg[k];
    act.mis    = om[k];
    act.ill    = oi[k];
    if (hold[k]) chk($sformatf("hold_p%0d", k + 1), 64'({ov[k], act}), 64'({1'b1, prev[k]}));
`ifdef BRANCH_BHT_EN
    chk($sformatf("bht_lookup_p%0d", k + 1), 64'(bt[k]), 64'(bm[k][bidx(bht_pc)] >= 2));
`endif
    if (ov[k] && out_ready) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        chk($sformatf("unexpected_out_p%0d", k + 1), 64'(1), 64'(0));
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("sb_p%0d", k + 1), 64'(act), 64'(e.r));
        if (!e.r.ill) begin
          if (e.r.taken) begin
            if (bm[k][bidx(e.pc)] < 3) bm[k][bidx(e.pc)]++;
          end else begin
            if (bm[k][bidx(e.pc)] > 0) bm[k][bidx(e.pc)]--;
          end
        end
      end
    end
    hold[k] = ov[k] && !out_ready && !flush;
    prev[k] = act;
    if (flush) begin
      if (k == 0) q0.delete(); else q1.delete();
    end else if (in_valid && ir[k]) begin
      e.r  = model(f3, rs1, rs2, pc, imm, pred);
      e.pc = pc;
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      hold[0] = 1'b0;
      hold[1] = 1'b0;
      bht_reset();
    end else begin
      mon(0);
      mon(1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] im, input logic pr);
    f3 = c; rs1 = a; rs2 = b; pc = p; imm = im; pred = pr;
  endtask

  task automatic rand_req();
    logic [31:0] a, b;
    int m;
    m = $urandom_range(0, 3);
    a = $urandom;
    b = $urandom;
    if (m == 0) b = a;
    if (m == 1) begin
      a = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0000_0001;
    end
    set_req(3'($urandom_range(0, 7)), a, b,
            ($urandom_range(0, 1) == 1) ? {24'h0, 6'($urandom), 2'b00} : $urandom,
            $urandom, 1'($urandom));
  endtask

  // One request through an empty pipe: PIPE=1 result after 1 cycle, PIPE=2 after 2
  task automatic drive_vec(input int i, input vec_t v);
    logic [35:0] exp;
    exp = {1'b1, v.tk, v.tg, v.mi, v.il};
    step();
    set_req(v.f3, v.a, v.b, v.pc, v.imm, v.pred);
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d_p1", i), 64'({ov[0], ot[0], otg[0], om[0], oi[0]}), 64'(exp));
    chk($sformatf("vec%0d_p2_lat", i), 64'(ov[1]), 64'(0));
    @(negedge clk);
    chk($sformatf("vec%0d_p1_gone", i), 64'(ov[0]), 64'(0));
    chk($sformatf("vec%0d_p2", i), 64'({ov[1], ot[1], otg[1], om[1], oi[1]}), 64'(exp));
  endtask

  vec_t vt [9];
  int   cnt [2];
  int   rdy [2];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    vt[0] = '{3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b1, 32'h120, 1'b1, 1'b0};
    vt[1] = '{3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b0, 32'h104, 1'b0, 1'b0};
    vt[2] = '{3'b111, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b1, 32'h120, 1'b1, 1'b0};
    vt[3] = '{3'b010, 32'h5,         32'h5, 32'h100, 32'h20, 1'b1, 1'b0, 32'h104, 1'b1, 1'b1};
    vt[4] = '{3'b000, 32'h5,         32'h5, 32'hFFFF_FFF0, 32'h20, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0};
    vt[5] = '{3'b001, 32'h5,         32'h5, 32'hFFFF_FFFC, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[6] = '{3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h200, 32'h40, 1'b1, 1'b0, 32'h204, 1'b1, 1'b0};
    vt[7] = '{3'b011, 32'h1,         32'h2, 32'h300, 32'h40, 1'b0, 1'b0, 32'h304, 1'b0, 1'b1};
    vt[8] = '{3'b100, 32'h8000_0000, 32'h0, 32'h400, 32'hFFFF_FFF0, 1'b1, 1'b1, 32'h3F0, 1'b0, 1'b0};

    rst_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_req(3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef BRANCH_BHT_EN
    bht_pc = 32'h40;
`endif
    #2 rst_n = 1'b0;
    #6;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_out_p%0d", k + 1), 64'({ov[k], ot[k], otg[k], om[k], oi[k]}), 64'(0));
      chk($sformatf("reset_in_ready_p%0d", k + 1), 64'(ir[k]), 64'(1));
    end
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 9; i++) drive_vec(i, vt[i]);

    // Backpressure: stall output while a stream of 4 requests arrives
    step();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_req();
      step();
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stall_in_ready_p%0d", k + 1), 64'(ir[k]), 64'(0));
      chk($sformatf("stall_out_valid_p%0d", k + 1), 64'(ov[k]), 64'(1));
    end
    step();
    out_ready = 1'b1;
    cnt = '{0, 0};
    rdy = '{0, 0};
    for (int c = 0; c < 8; c++) begin
      rand_req();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        cnt[k] += int'(ov[k]);
        rdy[k] += int'(ir[k]);
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stream_results_p%0d", k + 1), 64'(cnt[k]), 64'(8));
      chk($sformatf("stream_ready_p%0d", k + 1), 64'(rdy[k]), 64'(8));
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Flush with entries in flight: nothing from before the flush may emerge
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_req();
    step();
    rand_req();
    step();
    flush = 1'b1;
    rand_req();
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk($sformatf("flush_in_ready_p%0d", k + 1), 64'(ir[k]), 64'(1));
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cnt = '{0, 0};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) cnt[k] += int'(ov[k]);
      step();
    end
    for (int k = 0; k < 2; k++) chk($sformatf("flush_no_out_p%0d", k + 1), 64'(cnt[k]), 64'(0));

`ifdef BRANCH_BHT_EN
    // Predictor training at pc=0x40: three taken, then two not-taken
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bht_pc = 32'h40;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk($sformatf("bht_init_p%0d", k + 1), 64'(bt[k]), 64'(0));
    for (int u = 0; u < 5; u++) begin
      step();
      set_req((u < 3) ? 3'b000 : 3'b001, 32'h7, 32'h7, 32'h40, 32'h10, 1'b0);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (2) step();
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        chk($sformatf("bht_train%0d_p%0d", u, k + 1), 64'(bt[k]), 64'((u < 4) ? 1 : 0));
    end
    for (int u = 0; u < 2; u++) begin
      step();
      set_req(3'b000, 32'h7, 32'h7, 32'h40, 32'h10, 1'b0);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (2) step();
    end
`endif

    // Asynchronous reset in the middle of a stream
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(3'b000, 32'h3, 32'h3, 32'h40, 32'h10, 1'b1);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arst_out_valid_p%0d", k + 1), 64'(ov[k]), 64'(0));
      chk($sformatf("arst_in_ready_p%0d", k + 1), 64'(ir[k]), 64'(1));
`ifdef BRANCH_BHT_EN
      chk($sformatf("arst_bht_p%0d", k + 1), 64'(bt[k]), 64'(0));
`endif
    end
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk($sformatf("arst_after_p%0d", k + 1), 64'(ov[k]), 64'(0));

    // Random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      step();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 8);
      flush     = ($urandom_range(0, 31) == 0);
      rand_req();
`ifdef BRANCH_BHT_EN
      bht_pc = {24'h0, 6'($urandom), 2'b00};
`endif
    end
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    @(negedge clk);
    chk("drain_p1", 64'(q0.size()), 64'(0));
    chk("drain_p2", 64'(q1.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
